fir_channel_scheduler: RTL and testbench
========================================

// Module: fir_channel_scheduler
// PURPOSE
//  Time-multiplexes one shared FIR_Filter datapath across N_CH beamformer microphone channels.
//  Each channel's slow-rate sample is buffered and granted round-robin to the filter, tagged with
//  its channel index so the filter selects its delay-line/state bank; the filter result is
//  returned through a valid/ready port. Sits between the per-mic sample front end and the
//  beamformer summation stage.
// PARAMETERS
//  N_CH     4    number of requesting channels (>=2)
//  DATA_W   16   sample width (signed)
//  OUT_W    111  filter result width (signed)
//  TIMEOUT  256  max cycles to wait for fir_done before abandoning a job
// PORTS
//  clk         in   1             system clock, all logic on rising edge
//  rst         in   1             reset, asynchronous, active-low
//  ch_valid    in   N_CH          1-cycle pulse per channel: new sample on ch_data slice
//  ch_data     in   N_CH*DATA_W   channel i sample in bits [i*DATA_W +: DATA_W]
//  fir_valid   out  1             1-cycle issue strobe to filter
//  fir_data    out  DATA_W        sample issued to filter
//  fir_ch      out  CH_W          channel tag issued to filter (CH_W = $clog2(N_CH))
//  fir_done    in   1             1-cycle pulse: fir_result valid for the issued job
//  fir_result  in   OUT_W         filter output
//  out_valid   out  1             result available
//  out_ready   in   1             downstream accepts when out_valid & out_ready
//  out_data    out  OUT_W         captured result
//  out_ch      out  CH_W          channel the result belongs to
//  busy        out  1             state != IDLE
//  overrun     out  N_CH          sticky: sample overwritten before it was issued
//  timeout_err out  1             sticky: fir_done not seen within TIMEOUT cycles
//  clr_err     in   1             clears overrun and timeout_err
// BEHAVIOUR
//  Reset (rst=0): all outputs 0, pending flags clear, rr_ptr=0, state IDLE.
//  Capture: ch_valid[i] sets pending[i] and loads buf[i]. If pending[i] already set -> buf
//   overwritten with newest sample, overrun[i] set. Grant + ch_valid[i] in same cycle: the
//   grant takes the old buf[i]; pending[i] stays set holding the new sample; no overrun.
//  FSM IDLE: if any pending, grant = first pending index at/after rr_ptr (wrapping N_CH-1 -> 0);
//   latch buf[grant] and grant index, clear pending[grant], rr_ptr <= (grant+1) mod N_CH,
//   -> ISSUE. None pending -> stay.
//  ISSUE: fir_valid=1 for exactly this cycle, fir_data/fir_ch = latched values; clear wait
//   counter; -> WAIT. fir_data/fir_ch hold their values until the next issue.
//  WAIT: counter increments each cycle. fir_done -> out_data <= fir_result, out_ch <= tag,
//   -> OUTPUT. Counter reaches TIMEOUT-1 without fir_done -> timeout_err set, result
//   dropped, -> IDLE.
//  OUTPUT: out_valid=1; out_data/out_ch stable while out_valid. out_ready -> out_valid=0
//   next cycle, -> IDLE. Back-to-back: next grant evaluated in the cycle after acceptance.
//  fir_done outside WAIT is ignored.
//  Latency: ch_valid at edge t (idle, no other pending) -> fir_valid high in cycle t+2.
//  Error flags: clr_err clears them; a set event in the same cycle wins over the clear.
//  Async reset mid-job aborts: no output, pending samples discarded.
//  Width rules: no arithmetic on data; pointer arithmetic wraps mod N_CH (non-power-of-2 ok).
// STRUCTURE
//  beamformer_pkg: FSM state enum (IDLE, ISSUE, WAIT, OUTPUT) and default N_CH, DATA_W,
//   OUT_W constants.
//  Sub-module rr_arbiter (req vector + ptr -> one-hot grant + index, combinational).
//   Everything else is inline.
// TESTING
//  1) ch_valid[2] pulse, data 16'h0123, fir_done 5 cycles after fir_valid -> fir_valid
//     2 cycles later, fir_ch=2, fir_data=0123; out_valid with out_ch=2 and out_data=fir_result.
//  2) All 4 ch_valid pulse same cycle, rr_ptr=0 -> issue order 0,1,2,3; then ch 0,3 pending
//     -> order 0,3.
//  3) ch_valid[1] twice while blocked in OUTPUT (out_ready=0) -> overrun[1]=1, the second
//     sample issued; clr_err -> overrun=0.
//  4) fir_done withheld -> timeout_err=1 after TIMEOUT cycles, no out_valid, next pending
//     channel issued.
//  5) out_ready held low 20 cycles -> out_data/out_ch stable, no fir_valid until accepted.
//  6) rst low during WAIT -> all outputs 0 immediately; after release, no stale output.

Source files
------------

// File: rtl/beamformer_pkg.sv
// beamformer_pkg: shared types and defaults for the FIR channel scheduler.
//   Provides the scheduler FSM state enum, default sizing constants and a
//   modular-add helper so pointer math wraps correctly for any channel count.
package beamformer_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUTPUT} state_e;

    localparam int N_CH_DEF    = 4;
    localparam int DATA_W_DEF  = 16;
    localparam int OUT_W_DEF   = 111;
    localparam int TIMEOUT_DEF = 256;

    // (a + b) mod n, valid for 0 <= a, b < n; avoids a divider for non-power-of-2 n
    function automatic int wrap_add(input int a, input int b, input int n);
        return (a + b >= n) ? a + b - n : a + b;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at/after ptr.
//   req  in  N   request vector
//   ptr  in  CW  highest-priority index for this evaluation
//   gnt  out N   one-hot grant (all zero when no request)
//   idx  out CW  index of the granted request
//   any  out 1   at least one request present
module rr_arbiter
    import beamformer_pkg::*;
#(
    parameter  int N  = 4,
    localparam int CW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [CW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [CW-1:0] idx,
    output logic          any
);

    logic [CW-1:0] c;

    // Scan offsets from farthest to nearest so the nearest request wins last
    always_comb begin
        idx = '0;
        c   = '0;
        any = |req;
        for (int k = N - 1; k >= 0; k--) begin
            c = CW'(wrap_add(int'(ptr), k, N));
            if (req[c]) idx = c;
        end
        gnt      = '0;
        gnt[idx] = any;
    end

endmodule

// File: rtl/fir_channel_scheduler.sv
// fir_channel_scheduler: shares one FIR datapath across N_CH channels round-robin.
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-low reset
//   ch_valid     in   per-channel new-sample pulse
//   ch_data      in   channel i sample in [i*DATA_W +: DATA_W]
//   fir_valid    out  one-cycle issue strobe to the filter
//   fir_data     out  issued sample (held until next issue)
//   fir_ch       out  issued channel tag (held until next issue)
//   fir_done     in   filter result strobe, honoured only while waiting
//   fir_result   in   filter output
//   out_valid    out  result available downstream
//   out_ready    in   downstream accept
//   out_data     out  captured result
//   out_ch       out  channel of the captured result
//   busy         out  FSM not idle
//   overrun      out  sticky per channel: unissued sample overwritten
//   timeout_err  out  sticky: filter never answered an issued job
//   clr_err      in   clears the sticky error flags (a same-cycle set wins)
module fir_channel_scheduler
    import beamformer_pkg::*;
#(
    parameter  int N_CH    = N_CH_DEF,
    parameter  int DATA_W  = DATA_W_DEF,
    parameter  int OUT_W   = OUT_W_DEF,
    parameter  int TIMEOUT = TIMEOUT_DEF,
    localparam int CH_W    = $clog2(N_CH),
    localparam int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          ch_valid,
    input  logic [N_CH*DATA_W-1:0]   ch_data,
    output logic                     fir_valid,
    output logic [DATA_W-1:0]        fir_data,
    output logic [CH_W-1:0]          fir_ch,
    input  logic                     fir_done,
    input  logic [OUT_W-1:0]         fir_result,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         out_data,
    output logic [CH_W-1:0]          out_ch,
    output logic                     busy,
    output logic [N_CH-1:0]          overrun,
    output logic                     timeout_err,
    input  logic                     clr_err
);

    state_e                        state_q, state_d;
    logic [CH_W-1:0]               rr_ptr_q, rr_ptr_d;
    logic [N_CH-1:0]               pending_q, pending_d;
    logic [N_CH-1:0][DATA_W-1:0]   buf_q, buf_d;
    logic                          fir_valid_q, fir_valid_d;
    logic [DATA_W-1:0]             fir_data_q, fir_data_d;
    logic [CH_W-1:0]               fir_ch_q, fir_ch_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic                          out_valid_q, out_valid_d;
    logic [OUT_W-1:0]              out_data_q, out_data_d;
    logic [CH_W-1:0]               out_ch_q, out_ch_d;
    logic [N_CH-1:0]               overrun_q, overrun_d;
    logic                          timeout_q, timeout_d;

    logic [N_CH-1:0] gnt;
    logic [CH_W-1:0] gnt_idx;
    logic            any_req;
    logic            take;

    rr_arbiter #(.N(N_CH)) u_arb (
        .req (pending_q),
        .ptr (rr_ptr_q),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (any_req)
    );

    assign take = (state_q == IDLE) && any_req;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        fir_valid_d = 1'b0;
        fir_data_d  = fir_data_q;
        fir_ch_d    = fir_ch_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        overrun_d   = clr_err ? '0 : overrun_q;
        timeout_d   = clr_err ? 1'b0 : timeout_q;
        // A grant reads the old buffer entry, so a same-cycle new sample just re-arms pending
        for (int i = 0; i < N_CH; i++) begin
            buf_d[i]     = ch_valid[i] ? ch_data[i*DATA_W +: DATA_W] : buf_q[i];
            pending_d[i] = ch_valid[i] | (pending_q[i] & ~(take & gnt[i]));
            overrun_d[i] = overrun_d[i] | (ch_valid[i] & pending_q[i] & ~(take & gnt[i]));
        end
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d     = ISSUE;
                    fir_valid_d = 1'b1;
                    fir_data_d  = buf_q[gnt_idx];
                    fir_ch_d    = gnt_idx;
                    rr_ptr_d    = CH_W'(wrap_add(int'(gnt_idx), 1, N_CH));
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (fir_done) begin
                    state_d     = OUTPUT;
                    out_valid_d = 1'b1;
                    out_data_d  = fir_result;
                    out_ch_d    = fir_ch_q;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end
            end
            OUTPUT: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            pending_q   <= '0;
            buf_q       <= '0;
            fir_valid_q <= 1'b0;
            fir_data_q  <= '0;
            fir_ch_q    <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            overrun_q   <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            pending_q   <= pending_d;
            buf_q       <= buf_d;
            fir_valid_q <= fir_valid_d;
            fir_data_q  <= fir_data_d;
            fir_ch_q    <= fir_ch_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            overrun_q   <= overrun_d;
            timeout_q   <= timeout_d;
        end
    end

    assign fir_valid   = fir_valid_q;
    assign fir_data    = fir_data_q;
    assign fir_ch      = fir_ch_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_ch      = out_ch_q;
    assign busy        = (state_q != IDLE);
    assign overrun     = overrun_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_fir_channel_scheduler.sv
// tb_fir_channel_scheduler: directed self-checking bench for fir_channel_scheduler.
module tb_fir_channel_scheduler;

    logic         clk;
    logic         rst;
    logic [3:0]   ch_valid;
    logic [63:0]  ch_data;
    logic         fir_valid;
    logic [15:0]  fir_data;
    logic [1:0]   fir_ch;
    logic         fir_done;
    logic [110:0] fir_result;
    logic         out_valid;
    logic         out_ready;
    logic [110:0] out_data;
    logic [1:0]   out_ch;
    logic         busy;
    logic [3:0]   overrun;
    logic         timeout_err;
    logic         clr_err;

    int n_checks = 0;
    int n_fail   = 0;

    fir_channel_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .ch_valid    (ch_valid),
        .ch_data     (ch_data),
        .fir_valid   (fir_valid),
        .fir_data    (fir_data),
        .fir_ch      (fir_ch),
        .fir_done    (fir_done),
        .fir_result  (fir_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_ch      (out_ch),
        .busy        (busy),
        .overrun     (overrun),
        .timeout_err (timeout_err),
        .clr_err     (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [110:0] res_of(input int k);
        return {k[15:0], 31'h0, 64'hC0FF_EE00_0000_0000 + 64'(k)};
    endfunction

    task automatic pulse(input int ch, input logic [15:0] d);
        ch_valid     = '0;
        ch_valid[ch] = 1'b1;
        ch_data[ch*16 +: 16] = d;
        tick();
        ch_valid = '0;
    endtask

    task automatic wait_issue();
        int n = 0;
        while (!fir_valid && n < 40) begin
            tick();
            n++;
        end
        chk("issue_seen", fir_valid, 1'b1);
    endtask

    // Issue, answer one cycle into WAIT, and check the captured result
    task automatic start_job(input int ch, input logic [15:0] d, input logic [110:0] res);
        wait_issue();
        chk("fir_ch", fir_ch, ch);
        chk("fir_data", fir_data, d);
        tick();
        chk("fir_valid_one_cycle", fir_valid, 1'b0);
        fir_done   = 1'b1;
        fir_result = res;
        tick();
        fir_done = 1'b0;
        chk("out_valid", out_valid, 1'b1);
        chk("out_ch", out_ch, ch);
        chk("out_data", out_data, res);
    endtask

    task automatic accept();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("out_valid_drop", out_valid, 1'b0);
    endtask

    initial begin
        int n;
        logic saw;
        rst        = 1'b0;
        ch_valid   = '0;
        ch_data    = '0;
        fir_done   = 1'b0;
        fir_result = '0;
        out_ready  = 1'b0;
        clr_err    = 1'b0;
        tick();
        tick();
        chk("rst_fir_valid", fir_valid, 1'b0);
        chk("rst_fir_data", fir_data, 16'h0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 111'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_overrun", overrun, 4'h0);
        chk("rst_timeout", timeout_err, 1'b0);
        rst = 1'b1;
        tick();

        // Single request: two-cycle issue latency, done five cycles after issue
        pulse(2, 16'h0123);
        chk("lat_idle_cycle", fir_valid, 1'b0);
        tick();
        chk("lat_fir_valid", fir_valid, 1'b1);
        chk("lat_fir_ch", fir_ch, 2'd2);
        chk("lat_fir_data", fir_data, 16'h0123);
        chk("lat_busy", busy, 1'b1);
        for (int i = 0; i < 5; i++) tick();
        chk("t1_no_out_yet", out_valid, 1'b0);
        chk("t1_fir_data_hold", fir_data, 16'h0123);
        fir_done   = 1'b1;
        fir_result = res_of(1);
        tick();
        fir_done = 1'b0;
        chk("t1_out_valid", out_valid, 1'b1);
        chk("t1_out_ch", out_ch, 2'd2);
        chk("t1_out_data", out_data, res_of(1));
        accept();
        chk("t1_busy_idle", busy, 1'b0);

        // Move the pointer past channel 3 so it wraps to 0
        pulse(3, 16'h0333);
        start_job(3, 16'h0333, res_of(2));
        accept();

        // All four at once: round-robin order 0,1,2,3
        ch_valid = 4'hF;
        ch_data  = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
        tick();
        ch_valid = '0;
        for (int c = 0; c < 4; c++) begin
            start_job(c, 16'hA000 + 16'(c), res_of(10 + c));
            accept();
        end
        ch_valid = 4'b1001;
        ch_data  = {16'hB003, 16'h0, 16'h0, 16'hB000};
        tick();
        ch_valid = '0;
        start_job(0, 16'hB000, res_of(20));
        accept();
        start_job(3, 16'hB003, res_of(23));
        accept();

        // Overrun while blocked in OUTPUT; newest sample is the one issued
        pulse(0, 16'h00C0);
        start_job(0, 16'h00C0, res_of(30));
        pulse(1, 16'h1111);
        pulse(1, 16'h2222);
        chk("ovr_set", overrun, 4'b0010);
        chk("ovr_blocked_no_issue", fir_valid, 1'b0);
        accept();
        start_job(1, 16'h2222, res_of(31));
        accept();
        chk("ovr_sticky", overrun, 4'b0010);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("ovr_clear", overrun, 4'h0);

        // New sample in the grant cycle: old one issued, new one kept, no overrun
        pulse(2, 16'h0AAA);
        pulse(2, 16'h0BBB);
        start_job(2, 16'h0AAA, res_of(40));
        accept();
        chk("grant_same_cycle_no_ovr", overrun, 4'h0);
        start_job(2, 16'h0BBB, res_of(41));
        accept();

        // Timeout: fir_done withheld, result dropped, next channel served
        ch_valid = 4'b0011;
        ch_data  = {16'h0, 16'h0, 16'h6666, 16'h5555};
        tick();
        ch_valid = '0;
        wait_issue();
        chk("to_fir_ch", fir_ch, 2'd0);
        n   = 0;
        saw = 1'b0;
        while (!timeout_err && n < 300) begin
            tick();
            n++;
            saw = saw | out_valid;
        end
        chk("to_cycles", n, 257);
        chk("to_flag", timeout_err, 1'b1);
        chk("to_no_out", saw, 1'b0);
        start_job(1, 16'h6666, res_of(50));
        accept();
        chk("to_sticky", timeout_err, 1'b1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("to_clear", timeout_err, 1'b0);

        // Output held 20 cycles: stable, nothing issued until accepted
        pulse(2, 16'h2D2D);
        start_job(2, 16'h2D2D, res_of(60));
        pulse(3, 16'h3D3D);
        saw = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            saw = saw | (out_valid !== 1'b1) | (out_data !== res_of(60)) | (out_ch !== 2'd2) | fir_valid;
        end
        chk("hold_stable", saw, 1'b0);
        accept();
        start_job(3, 16'h3D3D, res_of(61));
        accept();

        // Asynchronous reset during WAIT aborts the job and pending samples
        pulse(1, 16'h6A6A);
        wait_issue();
        tick();
        pulse(0, 16'h7B7B);
        chk("pre_rst_busy", busy, 1'b1);
        rst = 1'b0;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_fir_data", fir_data, 16'h0);
        chk("arst_fir_ch", fir_ch, 2'd0);
        chk("arst_out_valid", out_valid, 1'b0);
        tick();
        rst = 1'b1;
        fir_done   = 1'b1;
        fir_result = res_of(70);
        tick();
        fir_done = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            saw = saw | fir_valid | out_valid | busy;
        end
        chk("post_rst_quiet", saw, 1'b0);
        chk("post_rst_out_data", out_data, 111'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
